// File: rtl/jtkicker_tile_romrq.sv
// -----------------------------------------------------------------------------
// jtkicker_tile_romrq
//
// SDRAM-side responder for a tile/scroll layer's ROM fetch port. The layer asks
// for a 32-bit word; this block fetches it as two 16-bit beats from a single
// SDRAM bank slot, assembles {beat1, beat0}, keeps it in a small cache and
// reports rom_ok only while the cached tag matches the address being asked for.
// One instance sits between each graphics layer and the bank arbiter.
//
// Parameters
//   AW     : layer address width, in 32-bit words
//   OFFSET : base of the region within the SDRAM bank, in 16-bit words
//   TOUT   : WAIT cycles without sdram_ack before the request is dropped for
//            one cycle and raised again
//
// Ports
//   clk        in   system clock, single domain
//   rst        in   synchronous active-high reset
//   rom_addr   in   [AW-1:0] requested 32-bit word address
//   rom_cs     in   request enable; no new fetch starts while low
//   rom_data   out  [31:0] assembled data {beat1, beat0}
//   rom_ok     out  rom_data belongs to the current rom_addr (combinational)
//   sdram_addr out  [21:0] 16-bit word address {fa, 1'b0} + OFFSET
//   sdram_req  out  bank request, held as a level until acknowledged
//   sdram_ack  in   one-cycle grant from the arbiter
//   sdram_dst  in   one-cycle data strobe, two per granted request
//   sdram_data in   [15:0] beat data, valid while sdram_dst is high
//
// Optional build macro
//   JTKICKER_ROMRQ_CACHE2_EN : two cache entries with a round-robin fill
//   pointer; rom_data becomes a combinational mux of the hitting entry.
//   Without it the block keeps a single cache entry.
// -----------------------------------------------------------------------------
module jtkicker_tile_romrq #(
  parameter int          AW     = 13,
  parameter logic [21:0] OFFSET = 22'h0,
  parameter int          TOUT   = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rom_addr,
  input  logic          rom_cs,
  output logic [31:0]   rom_data,
  output logic          rom_ok,
  output logic [21:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [15:0]   sdram_data
);

  // Counter just wide enough to hold TOUT.
  localparam int            CW        = (TOUT < 1) ? 1 : $clog2(TOUT + 1);
  // Last count with the request still raised; the next WAIT cycle has it low.
  localparam logic [CW-1:0] TOUT_LAST = CW'(TOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BEAT0 = 2'd2,
    ST_BEAT1 = 2'd3
  } state_t;

  // SDRAM word address of a 32-bit layer word; the 22-bit sum wraps silently.
  function automatic logic [21:0] fetch_addr(input logic [AW-1:0] a);
    logic [21:0] word;
    word = 22'({a, 1'b0});
    return word + OFFSET;
  endfunction

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] fa;
  logic [AW-1:0] fa_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [15:0]   low;
  logic [15:0]   low_nxt;
  logic          req_nxt;
  logic [21:0]   addr_nxt;
  logic          fill;
  logic [31:0]   fill_data;
  logic          hit;

  // Cache entry 0 (always present)
  logic [AW-1:0] tag0;
  logic [31:0]   data0;
  logic          valid0;
  logic          hit0;

  assign hit0      = valid0 & (tag0 == rom_addr);
  assign fill_data = {sdram_data, low};

`ifdef JTKICKER_ROMRQ_CACHE2_EN
  // Second entry and the round-robin victim pointer
  logic [AW-1:0] tag1;
  logic [31:0]   data1;
  logic          valid1;
  logic          hit1;
  logic          ptr;

  assign hit1     = valid1 & (tag1 == rom_addr);
  assign hit      = hit0 | hit1;
  // Data follows whichever entry hits; entry 0 is shown otherwise.
  assign rom_data = hit1 ? data1 : data0;
`else
  assign hit      = hit0;
  assign rom_data = data0;
`endif

  assign rom_ok = hit & rom_cs;

  // Next-state and next-value logic for the fetch sequencer
  always_comb begin
    state_nxt = state;
    fa_nxt    = fa;
    cnt_nxt   = cnt;
    low_nxt   = low;
    req_nxt   = sdram_req;
    addr_nxt  = sdram_addr;
    fill      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rom_cs && !hit) begin
          fa_nxt    = rom_addr;
          addr_nxt  = fetch_addr(rom_addr);
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A grant only counts while the request is actually raised.
        if (sdram_req && sdram_ack) begin
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ST_BEAT0;
        end else if (!sdram_req) begin
          // The one-cycle drop after a timeout is over: raise it again,
          // same fa and sdram_addr.
          req_nxt = 1'b1;
          cnt_nxt = '0;
        end else if (cnt == TOUT_LAST) begin
          // The counter reaches TOUT in the cycle the request is low.
          req_nxt = 1'b0;
          cnt_nxt = cnt + CW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_BEAT0: begin
        if (sdram_dst) begin
          low_nxt   = sdram_data;
          state_nxt = ST_BEAT1;
        end else begin
          state_nxt = ST_BEAT0;
        end
      end
      ST_BEAT1: begin
        if (sdram_dst) begin
          fill      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_BEAT1;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, latched fetch address, request and staging registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fa         <= '0;
      cnt        <= '0;
      low        <= 16'h0000;
      sdram_req  <= 1'b0;
      sdram_addr <= OFFSET;
    end else begin
      state      <= state_nxt;
      fa         <= fa_nxt;
      cnt        <= cnt_nxt;
      low        <= low_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
    end
  end

`ifdef JTKICKER_ROMRQ_CACHE2_EN
  // Two-entry cache: the fill lands in the entry the pointer selects, tag and
  // data in the same edge, then the pointer moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag0   <= '0;
      data0  <= 32'h0000_0000;
      valid0 <= 1'b0;
      tag1   <= '0;
      data1  <= 32'h0000_0000;
      valid1 <= 1'b0;
      ptr    <= 1'b0;
    end else if (fill) begin
      if (ptr == 1'b0) begin
        tag0   <= fa;
        data0  <= fill_data;
        valid0 <= 1'b1;
      end else begin
        tag1   <= fa;
        data1  <= fill_data;
        valid1 <= 1'b1;
      end
      ptr <= ~ptr;
    end else begin
      ptr <= ptr;
    end
  end
`else
  // Single-entry cache: tag, data and valid update together on the last beat,
  // so there is never a cycle with a stale tag paired with fresh data.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag0   <= '0;
      data0  <= 32'h0000_0000;
      valid0 <= 1'b0;
    end else if (fill) begin
      tag0   <= fa;
      data0  <= fill_data;
      valid0 <= 1'b1;
    end else begin
      valid0 <= valid0;
    end
  end
`endif

endmodule

// File: doc/jtkicker_tile_romrq.md
Name: jtkicker_tile_romrq

Overview:
- SDRAM-side responder for the tile/scroll layer's ROM fetch interface.
- The layer presents a 32-bit-word ROM address and expects 32-bit data plus an ok flag; this block serves it.
- It fetches two 16-bit beats from one SDRAM bank slot, assembles them, caches the result, and qualifies ok against the currently requested address.
- Sits between the layer and the SDRAM bank arbiter, one instance per graphics layer.

Parameters:
- AW, 13, layer address width (32-bit words).
- OFFSET, 22'h0, base of the region within the SDRAM bank, in 16-bit words.
- TOUT, 63, cycles without sdram_ack before the request is dropped and retried.

Ports:
- clk  in  1  system clock (48 MHz); single clock domain.
- rst  in  1  reset, synchronous, active-high.
- rom_addr  in  AW  requested 32-bit word address from the layer.
- rom_cs  in  1  request enable; when low, no new fetch starts.
- rom_data  out  32  assembled data: {beat1, beat0}.
- rom_ok  out  1  high when rom_data belongs to the current rom_addr.
- sdram_addr  out  22  16-bit word address = {rom_addr latched, 1'b0} + OFFSET.
- sdram_req  out  1  bank request; level held until ack.
- sdram_ack  in  1  one-cycle grant from the arbiter.
- sdram_dst  in  1  one-cycle data strobe; exactly two per granted request.
- sdram_data  in  16  beat data, valid while sdram_dst is high.

Behaviour:
- Reset values:
  - rom_data=0, rom_ok=0, sdram_req=0, sdram_addr=OFFSET.
  - Cache invalid, state IDLE, timeout counter 0.
- Cache: one entry holding tag[AW-1:0], data[31:0] and valid.
- rom_ok is combinational: valid & (tag==rom_addr) & rom_cs. rom_data is the cache data register.
- States:
  - IDLE: if rom_cs and cache miss, latch fa<=rom_addr, drive sdram_addr from fa, set sdram_req=1, go to WAIT.
  - WAIT: hold req and sdram_addr stable. On sdram_ack, drop req the next cycle and go to BEAT0.
    - Counter increments each WAIT cycle. When it reaches TOUT: req=0 for exactly one cycle, counter cleared, back to WAIT with req=1 and the same fa.
  - BEAT0: on sdram_dst, store sdram_data into the low half of a staging register, go to BEAT1.
  - BEAT1: on sdram_dst, write {sdram_data, low} to cache data, tag<=fa, valid<=1, go to IDLE.
- Fetch-to-ok latency from a miss, with ack in the cycle after req rises and back-to-back strobes: req at cycle 1, ack at 2, beats at 3..4, rom_ok at cycle 5.
- Address change mid-fetch:
  - The fetch in progress always completes under tag fa; it is never aborted.
  - Back in IDLE, a miss on the new address starts a new fetch in the next cycle.
  - rom_ok stays 0 throughout, unless the new address equals the old cached tag, in which case it rises immediately.
- During the BEAT1 write, valid drops for zero cycles: tag and data update atomically in the same edge.
- sdram_dst outside BEAT0/BEAT1 is ignored. sdram_ack outside WAIT is ignored.
- rom_cs low: IDLE does not start fetches. An active fetch completes normally.
- Reset mid-operation: req is 0 on the cycle after rst and the state is IDLE. Stray strobes from the aborted request are ignored because BEAT states are reached only via ack.
- Address arithmetic: sdram_addr is a 22-bit sum modulo 2^22 (wraps silently).

Optional Feature:
- Macro: JTKICKER_ROMRQ_CACHE2_EN.
- When defined:
  - Two cache entries; rom_ok is a hit in either entry.
  - rom_data is muxed from the hitting entry and is combinational on a hit.
  - Fills replace the entry pointed to by a 1-bit round-robin pointer, which toggles after each fill and resets to 0.
- When undefined: single entry exactly as in Behaviour.

Test Plan:
- Cold miss: rst for 4 cycles, rom_cs=1, rom_addr=13'h0A5, OFFSET=0. Ack one cycle after req, beats 16'h3412 then 16'h7856 -> sdram_addr=22'h14A, rom_data=32'h78563412, rom_ok=1 on cycle 5.
- Hit: hold rom_addr=13'h0A5 after the fill -> no further sdram_req for 100 cycles; rom_ok stays 1.
- Mid-fetch change: switch rom_addr to 13'h0A6 during BEAT0.
  - Fetch of 0A5 completes, then req rises with sdram_addr=22'h14C; rom_ok=0 until the 0A6 data lands.
  - CACHE2_EN: switching back to 0A5 gives rom_ok=1 immediately.
- Timeout: TOUT=7, never ack -> req falls for 1 cycle every 8 WAIT cycles with sdram_addr unchanged; ack after 20 cycles -> normal completion.
- Reset mid-fetch: assert rst between the two strobes, then feed one stray sdram_dst -> rom_ok=0, valid=0, state IDLE, stray beat not captured.
- Offset wrap: OFFSET=22'h3FFFFE, rom_addr=1 -> sdram_addr=22'h000000.
